complex_addsub_pipe: RTL and testbench

//  Pipelined complex add/subtract unit with valid/ready handshake, per-sample add/sub
//  and divide-by-2 scaling, selectable saturate or wrap, and a sticky overflow counter.

---
 rtl/complex_addsub_pipe.sv | 112 +++++++++++
 tb/tb_complex_addsub_pipe.sv | 344 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/complex_addsub_pipe.sv
// Two-stage pipelined complex add/subtract with valid/ready handshake,
// optional halving, saturate-or-wrap output and a sticky overflow counter.
module complex_addsub_pipe #(
    parameter int unsigned WIDTH    = 16,
    parameter bit          SATURATE = 1'b1,
    parameter int unsigned CNT_W    = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a_real,
    input  logic [WIDTH-1:0] a_imag,
    input  logic [WIDTH-1:0] b_real,
    input  logic [WIDTH-1:0] b_imag,
    input  logic             sub,
    input  logic             scale,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum_real,
    output logic [WIDTH-1:0] sum_imag,
    output logic             overflow,
    output logic [CNT_W-1:0] ovf_count,
    input  logic             ovf_clr
);

    localparam int unsigned TW = WIDTH + 1;

    logic          s1_valid;
    logic [TW-1:0] s1_t_real;
    logic [TW-1:0] s1_t_imag;
    logic          s1_scale;

    logic             s1_adv;
    logic             s2_adv;
    logic [WIDTH-1:0] res_real;
    logic [WIDTH-1:0] res_imag;
    logic             ovf_real;
    logic             ovf_imag;
    logic             cnt_evt;

    // Fold an exact WIDTH+1-bit temp back to WIDTH bits; MSB of return is the overflow flag.
    function automatic logic [WIDTH:0] fit(input logic [TW-1:0] t, input logic scl);
        logic [WIDTH:0] r;
        r = {1'b0, t[WIDTH-1:0]};
        if (scl) begin
            r = {1'b0, t[WIDTH:1]};
        end else if (t[WIDTH] != t[WIDTH-1]) begin
            r[WIDTH] = 1'b1;
            if (SATURATE) begin
                r[WIDTH-1:0] = t[WIDTH] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
            end
        end
        return r;
    endfunction

    assign s2_adv   = ~out_valid | out_ready;
    assign s1_adv   = ~s1_valid | s2_adv;
    assign in_ready = s1_adv;
    assign cnt_evt  = out_valid & out_ready & overflow;

    assign {ovf_real, res_real} = fit(s1_t_real, s1_scale);
    assign {ovf_imag, res_imag} = fit(s1_t_imag, s1_scale);

    // Stage 1: exact sign-extended sum/difference.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid  <= 1'b0;
            s1_t_real <= '0;
            s1_t_imag <= '0;
            s1_scale  <= 1'b0;
        end else if (s1_adv) begin
            s1_valid <= in_valid;
            if (in_valid) begin
                s1_t_real <= sub ? ({a_real[WIDTH-1], a_real} - {b_real[WIDTH-1], b_real})
                                 : ({a_real[WIDTH-1], a_real} + {b_real[WIDTH-1], b_real});
                s1_t_imag <= sub ? ({a_imag[WIDTH-1], a_imag} - {b_imag[WIDTH-1], b_imag})
                                 : ({a_imag[WIDTH-1], a_imag} + {b_imag[WIDTH-1], b_imag});
                s1_scale  <= scale;
            end
        end
    end

    // Stage 2: scaled/clamped result and overflow flag, held while downstream stalls.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid <= 1'b0;
            sum_real  <= '0;
            sum_imag  <= '0;
            overflow  <= 1'b0;
        end else if (s2_adv) begin
            out_valid <= s1_valid;
            if (s1_valid) begin
                sum_real <= res_real;
                sum_imag <= res_imag;
                overflow <= ovf_real | ovf_imag;
            end
        end
    end

    // Saturating count of delivered overflowed samples; clear wins, then the coincident event counts.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ovf_count <= '0;
        end else if (ovf_clr) begin
            ovf_count <= {{(CNT_W-1){1'b0}}, cnt_evt};
        end else if (cnt_evt && (ovf_count != {CNT_W{1'b1}})) begin
            ovf_count <= ovf_count + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_complex_addsub_pipe.sv
// Bench for complex_addsub_pipe: saturating, wrapping and 4-bit-counter instances
// share one stimulus stream and are checked against an integer reference model.
module tb_complex_addsub_pipe;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic in_valid = 1'b0;
    logic out_ready = 1'b1;
    logic sub = 1'b0;
    logic scale = 1'b0;
    logic ovf_clr = 1'b0;
    logic signed [15:0] a_real = '0, a_imag = '0, b_real = '0, b_imag = '0;

    logic        in_ready_s, out_valid_s, overflow_s;
    logic [15:0] sum_real_s, sum_imag_s, ovf_count_s;
    logic        in_ready_w, out_valid_w, overflow_w;
    logic [15:0] sum_real_w, sum_imag_w, ovf_count_w;
    logic        in_ready_c, out_valid_c, overflow_c;
    logic [15:0] sum_real_c, sum_imag_c;
    logic [3:0]  ovf_count_c;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    complex_addsub_pipe #(.WIDTH(16), .SATURATE(1'b1), .CNT_W(16)) u_sat (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_s),
        .a_real(a_real), .a_imag(a_imag), .b_real(b_real), .b_imag(b_imag),
        .sub(sub), .scale(scale), .out_valid(out_valid_s), .out_ready(out_ready),
        .sum_real(sum_real_s), .sum_imag(sum_imag_s), .overflow(overflow_s),
        .ovf_count(ovf_count_s), .ovf_clr(ovf_clr));

    complex_addsub_pipe #(.WIDTH(16), .SATURATE(1'b0), .CNT_W(16)) u_wrap (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_w),
        .a_real(a_real), .a_imag(a_imag), .b_real(b_real), .b_imag(b_imag),
        .sub(sub), .scale(scale), .out_valid(out_valid_w), .out_ready(out_ready),
        .sum_real(sum_real_w), .sum_imag(sum_imag_w), .overflow(overflow_w),
        .ovf_count(ovf_count_w), .ovf_clr(ovf_clr));

    complex_addsub_pipe #(.WIDTH(16), .SATURATE(1'b1), .CNT_W(4)) u_cnt4 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_c),
        .a_real(a_real), .a_imag(a_imag), .b_real(b_real), .b_imag(b_imag),
        .sub(sub), .scale(scale), .out_valid(out_valid_c), .out_ready(out_ready),
        .sum_real(sum_real_c), .sum_imag(sum_imag_c), .overflow(overflow_c),
        .ovf_count(ovf_count_c), .ovf_clr(ovf_clr));

    typedef struct {
        logic [15:0] rs, is_, rw, iw;
        bit          ov;
    } exp_t;

    exp_t exp_q[$];

    // Reference: exact integer result, then halve (floor) or range-limit.
    function automatic void model(input int a, input int b, input bit sb, input bit sc,
                                  input bit sat, output logic [15:0] r, output bit ov);
        int t;
        t  = sb ? a - b : a + b;
        ov = 1'b0;
        if (sc) begin
            t = (t - (t & 1)) / 2;
        end else if (t > 32767) begin
            ov = 1'b1;
            t  = sat ? 32767 : t - 65536;
        end else if (t < -32768) begin
            ov = 1'b1;
            t  = sat ? -32768 : t + 65536;
        end
        r = 16'(t);
    endfunction

    function automatic exp_t predict(input logic signed [15:0] ar, ai, br, bi, input bit sb, sc);
        exp_t e;
        bit o1, o2, o3, o4;
        model(int'(ar), int'(br), sb, sc, 1'b1, e.rs, o1);
        model(int'(ai), int'(bi), sb, sc, 1'b1, e.is_, o2);
        model(int'(ar), int'(br), sb, sc, 1'b0, e.rw, o3);
        model(int'(ai), int'(bi), sb, sc, 1'b0, e.iw, o4);
        e.ov = o1 | o2;
        return e;
    endfunction

    function automatic logic signed [15:0] pick();
        case ($urandom_range(0, 4))
            0:       return 16'sh7FFF;
            1:       return 16'sh8000;
            default: return 16'($urandom);
        endcase
    endfunction

    // Drive one sample with out_ready=1; returns at the sampling point two cycles later.
    task automatic issue(input logic signed [15:0] ar, ai, br, bi, input bit sb, sc,
                         output bit early);
        @(posedge clk); #1;
        a_real = ar; a_imag = ai; b_real = br; b_imag = bi;
        sub = sb; scale = sc; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(negedge clk);
        early = out_valid_s;
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b1; out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if ({out_valid_s, overflow_s, sum_real_s, sum_imag_s, ovf_count_s} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: got v=%0b ov=%0b r=%h i=%h cnt=%0d want all zero",
                     out_valid_s, overflow_s, sum_real_s, sum_imag_s, ovf_count_s);
        end
        checks++;
        if (in_ready_s !== 1'b1) begin
            errors++;
            $display("FAIL reset_in_ready: got %b want 1", in_ready_s);
        end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_directed();
        int tv[4][11] = '{
            '{  1000, -2000,   300,   500, 0, 0,   1300, -1500, 0,   1300, -1500},
            '{ 32767,     0,     1,     0, 0, 0,  32767,     0, 1, -32768,     0},
            '{-32768,-32768, 32767,-32768, 1, 0, -32768,     0, 1,      1,     0},
            '{-32768,-32768, 32767,-32768, 1, 1, -32768,     0, 0, -32768,     0}};
        bit early;
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            issue(16'(tv[i][0]), 16'(tv[i][1]), 16'(tv[i][2]), 16'(tv[i][3]),
                  tv[i][4] != 0, tv[i][5] != 0, early);
            checks++;
            if (early !== 1'b0 || out_valid_s !== 1'b1) begin
                errors++;
                $display("FAIL latency[%0d]: got valid@1=%b valid@2=%b want 0,1", i, early, out_valid_s);
            end
            checks++;
            if (sum_real_s !== 16'(tv[i][6]) || sum_imag_s !== 16'(tv[i][7]) ||
                overflow_s !== (tv[i][8] != 0)) begin
                errors++;
                $display("FAIL sat_vec[%0d]: got (%0d,%0d) ovf=%b want (%0d,%0d) ovf=%0d", i,
                         $signed(sum_real_s), $signed(sum_imag_s), overflow_s, tv[i][6], tv[i][7], tv[i][8]);
            end
            checks++;
            if (sum_real_w !== 16'(tv[i][9]) || sum_imag_w !== 16'(tv[i][10]) ||
                overflow_w !== (tv[i][8] != 0)) begin
                errors++;
                $display("FAIL wrap_vec[%0d]: got (%0d,%0d) ovf=%b want (%0d,%0d) ovf=%0d", i,
                         $signed(sum_real_w), $signed(sum_imag_w), overflow_w, tv[i][9], tv[i][10], tv[i][8]);
            end
            @(posedge clk); #1;
        end
        checks++;
        if (ovf_count_s !== 16'd2 || ovf_count_c !== 4'd2) begin
            errors++;
            $display("FAIL directed_count: got %0d/%0d want 2/2", ovf_count_s, ovf_count_c);
        end
    endtask

    task automatic test_ovf_count();
        bit early;
        out_ready = 1'b1;
        @(posedge clk); #1; ovf_clr = 1'b1;
        @(posedge clk); #1; ovf_clr = 1'b0;
        checks++;
        if (ovf_count_s !== 16'd0 || ovf_count_c !== 4'd0) begin
            errors++;
            $display("FAIL clr_idle: got %0d/%0d want 0/0", ovf_count_s, ovf_count_c);
        end
        for (int i = 0; i < 24; i++) begin
            issue(16'sh7FFF, 16'sh0000, 16'sh0001, 16'sh0000, 1'b0, 1'b0, early);
            if (i == 3) ovf_clr = 1'b1;
            @(posedge clk); #1;
            ovf_clr = 1'b0;
            if (i == 2) begin
                checks++;
                if (ovf_count_s !== 16'd3 || ovf_count_c !== 4'd3) begin
                    errors++;
                    $display("FAIL count_three: got %0d/%0d want 3/3", ovf_count_s, ovf_count_c);
                end
            end else if (i == 3) begin
                checks++;
                if (ovf_count_s !== 16'd1 || ovf_count_c !== 4'd1) begin
                    errors++;
                    $display("FAIL clr_and_count: got %0d/%0d want 1/1", ovf_count_s, ovf_count_c);
                end
            end
        end
        checks++;
        if (ovf_count_s !== 16'd21 || ovf_count_c !== 4'd15) begin
            errors++;
            $display("FAIL count_saturate: got %0d/%0d want 21/15", ovf_count_s, ovf_count_c);
        end
    endtask

    task automatic test_stream();
        exp_t        e;
        bit          held, evt, exp_rdy;
        logic [15:0] h_r, h_i;
        logic        h_o;
        int unsigned cnt16, cnt4;
        exp_q.delete();
        held = 1'b0; h_r = '0; h_i = '0; h_o = 1'b0;
        @(posedge clk); #1; ovf_clr = 1'b1;
        @(posedge clk); #1; ovf_clr = 1'b0;
        cnt16 = 0; cnt4 = 0;
        for (int cyc = 0; cyc < 700; cyc++) begin
            if (cyc >= 400 && exp_q.size() == 0) break;
            @(posedge clk); #1;
            if (cyc < 400) begin
                in_valid  = $urandom_range(0, 3) != 0;
                a_real = pick(); a_imag = pick(); b_real = pick(); b_imag = pick();
                sub       = 1'($urandom_range(0, 1));
                scale     = $urandom_range(0, 3) == 0;
                out_ready = (cyc < 48) ? (cyc % 3 == 0) : 1'($urandom_range(0, 1));
                ovf_clr   = $urandom_range(0, 15) == 0;
            end else begin
                in_valid = 1'b0; out_ready = 1'b1; ovf_clr = 1'b0;
            end
            @(negedge clk);
            exp_rdy = (exp_q.size() < 2) || out_ready;
            checks++;
            if (in_ready_s !== exp_rdy || in_ready_w !== exp_rdy || in_ready_c !== exp_rdy) begin
                errors++;
                $display("FAIL in_ready@%0d: got %b%b%b want %b", cyc, in_ready_s, in_ready_w, in_ready_c, exp_rdy);
            end
            if (held) begin
                checks++;
                if (out_valid_s !== 1'b1 || sum_real_s !== h_r || sum_imag_s !== h_i || overflow_s !== h_o) begin
                    errors++;
                    $display("FAIL stall_hold@%0d: got v=%b (%h,%h,%b) want v=1 (%h,%h,%b)",
                             cyc, out_valid_s, sum_real_s, sum_imag_s, overflow_s, h_r, h_i, h_o);
                end
            end
            checks++;
            if (ovf_count_s !== 16'(cnt16) || ovf_count_c !== 4'(cnt4)) begin
                errors++;
                $display("FAIL stream_count@%0d: got %0d/%0d want %0d/%0d", cyc, ovf_count_s, ovf_count_c, cnt16, cnt4);
            end
            evt = 1'b0;
            if (out_valid_s && out_ready) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL spurious_output@%0d: got valid output want none", cyc);
                end else begin
                    e = exp_q.pop_front();
                    evt = e.ov;
                    if (sum_real_s !== e.rs || sum_imag_s !== e.is_ || overflow_s !== e.ov ||
                        sum_real_w !== e.rw || sum_imag_w !== e.iw || overflow_w !== e.ov ||
                        out_valid_w !== 1'b1 || out_valid_c !== 1'b1 ||
                        sum_real_c !== e.rs || sum_imag_c !== e.is_ || overflow_c !== e.ov) begin
                        errors++;
                        $display("FAIL stream_data@%0d: got s(%h,%h,%b) w(%h,%h,%b) want s(%h,%h) w(%h,%h) ovf=%b",
                                 cyc, sum_real_s, sum_imag_s, overflow_s, sum_real_w, sum_imag_w, overflow_w,
                                 e.rs, e.is_, e.rw, e.iw, e.ov);
                    end
                end
            end
            if (ovf_clr) begin
                cnt16 = evt ? 1 : 0;
                cnt4  = evt ? 1 : 0;
            end else if (evt) begin
                if (cnt16 < 65535) cnt16++;
                if (cnt4 < 15) cnt4++;
            end
            held = out_valid_s && !out_ready;
            h_r = sum_real_s; h_i = sum_imag_s; h_o = overflow_s;
            if (in_valid && in_ready_s) exp_q.push_back(predict(a_real, a_imag, b_real, b_imag, sub, scale));
        end
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL stream_drain: got %0d samples undelivered want 0", exp_q.size());
        end
        ovf_clr = 1'b0;
    endtask

    task automatic test_reset_midflight();
        bit early;
        out_ready = 1'b1;
        issue(16'sh7FFF, 16'sh7FFF, 16'sh0001, 16'sh0001, 1'b0, 1'b0, early);
        @(posedge clk); #1;
        out_ready = 1'b0;
        a_real = 16'sd5; a_imag = 16'sd6; b_real = 16'sd7; b_imag = 16'sd8;
        sub = 1'b0; scale = 1'b0; in_valid = 1'b1;
        @(posedge clk); #1;
        a_real = 16'sd9;
        @(posedge clk); #1;
        in_valid = 1'b0;
        #2 rst = 1'b1;
        #1;
        checks++;
        if ({out_valid_s, overflow_s, sum_real_s, sum_imag_s, ovf_count_s, out_valid_w, out_valid_c, ovf_count_c} !== '0) begin
            errors++;
            $display("FAIL midflight_reset: got v=%b%b%b r=%h i=%h cnt=%0d/%0d want all zero",
                     out_valid_s, out_valid_w, out_valid_c, sum_real_s, sum_imag_s, ovf_count_s, ovf_count_c);
        end
        checks++;
        if (in_ready_s !== 1'b1) begin
            errors++;
            $display("FAIL midflight_in_ready: got %b want 1", in_ready_s);
        end
        @(negedge clk);
        rst = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++;
            if (out_valid_s !== 1'b0 || in_ready_s !== 1'b1) begin
                errors++;
                $display("FAIL residue[%0d]: got valid=%b ready=%b want 0,1", i, out_valid_s, in_ready_s);
            end
        end
        issue(16'sd1000, -16'sd2000, 16'sd300, 16'sd500, 1'b0, 1'b0, early);
        checks++;
        if (early !== 1'b0 || out_valid_s !== 1'b1 || sum_real_s !== 16'(1300) || sum_imag_s !== 16'(-1500)) begin
            errors++;
            $display("FAIL post_reset_sample: got v=%b%b (%0d,%0d) want v=01 (1300,-1500)",
                     early, out_valid_s, $signed(sum_real_s), $signed(sum_imag_s));
        end
        @(posedge clk); #1;
    endtask

    initial begin
        test_reset();
        test_directed();
        test_ovf_count();
        test_stream();
        test_reset_midflight();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog expired");
    end

endmodule
